// File: rtl/alien_bomb_pool.sv
// alien_bomb_pool: alien bomb slots with random column firing, per-frame descent,
// cannon collision, lives and game-over.
module alien_bomb_pool #(
    parameter int          NUM_BOMBS     = 4,
    parameter int          NUM_COLUMNS   = 8,
    parameter int          BOMB_W        = 2,
    parameter int          BOMB_H        = 8,
    parameter int          SPEED         = 2,
    parameter int          FLOOR_Y       = 470,
    parameter int          FIRE_PERIOD   = 32,
    parameter int          BOMB_X_OFF    = 7,
    parameter int          LIVES_INIT    = 3,
    parameter int          INVULN_FRAMES = 60,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         restart,
    input  logic                         frame_tick,
    input  logic [9:0]                   hpos,
    input  logic [9:0]                   vpos,
    input  logic [NUM_COLUMNS-1:0]       col_alive,
    input  logic [NUM_COLUMNS-1:0][9:0]  col_x,
    input  logic [NUM_COLUMNS-1:0][9:0]  col_bottom_y,
    input  logic                         cannon_gfx,
    output logic                         bomb_gfx,
    output logic [NUM_BOMBS-1:0]         active_mask,
    output logic [1:0]                   lives,
    output logic                         cannon_hit,
    output logic                         game_over
);
    localparam int FW = $clog2(FIRE_PERIOD + 2);
    localparam int IW = $clog2(INVULN_FRAMES + 2);

    logic [NUM_BOMBS-1:0]        active, hit, pix, hit_set, free_sel, floor_hit;
    logic [NUM_BOMBS-1:0][9:0]   bx, by;
    logic [NUM_BOMBS-1:0][10:0]  step_y;
    logic [15:0]                 lfsr, lfsr_n;
    logic [7:0]                  sel;
    logic [9:0]                  sp_x, sp_y;
    logic                        col_ok, found, attempt, do_fire, take_hit;
    logic [FW-1:0]               fire_cnt, fc_n;
    logic [IW-1:0]               invuln;

    assign game_over   = lives == 2'd0;
    assign active_mask = game_over ? '0 : active;
    assign bomb_gfx    = enable && |pix;
    assign hit_set     = pix & {NUM_BOMBS{cannon_gfx && enable}};

    always_comb begin
        lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        sel = lfsr_n[7:0] % 8'(NUM_COLUMNS);
        col_ok = 1'b0;
        sp_x = '0;
        sp_y = '0;
        for (int c = 0; c < NUM_COLUMNS; c++)
            if (sel == 8'(c)) begin
                col_ok = col_alive[c];
                sp_x = col_x[c] + 10'(BOMB_X_OFF);
                sp_y = col_bottom_y[c];
            end
        free_sel = '0;
        found = 1'b0;
        pix = '0;
        step_y = '0;
        floor_hit = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            free_sel[i] = !active[i] && !found;
            found = found || !active[i];
            step_y[i] = {1'b0, by[i]} + 11'(SPEED);
            floor_hit[i] = step_y[i] >= 11'(FLOOR_Y);
            pix[i] = active_mask[i]
                && hpos >= bx[i] && {1'b0, hpos} < {1'b0, bx[i]} + 11'(BOMB_W)
                && vpos >= by[i] && {1'b0, vpos} < {1'b0, by[i]} + 11'(BOMB_H);
        end
        fc_n = fire_cnt - FW'(1);
        attempt = fc_n == '0;
        do_fire = attempt && col_ok && found;
        take_hit = |hit && invuln == '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active     <= '0;
            hit        <= '0;
            bx         <= '0;
            by         <= '0;
            lives      <= 2'(LIVES_INIT);
            cannon_hit <= 1'b0;
            lfsr       <= LFSR_SEED;
            fire_cnt   <= FW'(FIRE_PERIOD);
            invuln     <= '0;
        end else begin
            cannon_hit <= 1'b0;
            if (frame_tick)
                lfsr <= lfsr_n;
            if (restart) begin
                lives    <= 2'(LIVES_INIT);
                active   <= '0;
                hit      <= '0;
                fire_cnt <= FW'(FIRE_PERIOD);
                invuln   <= '0;
            end else if (game_over) begin
                active <= '0;
                hit    <= '0;
            end else if (enable && frame_tick) begin
                // latches set this very cycle survive into the next frame
                hit      <= hit_set;
                fire_cnt <= !attempt ? fc_n : do_fire ? FW'(FIRE_PERIOD) : FW'(1);
                invuln   <= take_hit ? IW'(INVULN_FRAMES) : invuln != '0 ? invuln - IW'(1) : invuln;
                if (take_hit) begin
                    lives      <= lives - 2'd1;
                    cannon_hit <= 1'b1;
                end
                for (int i = 0; i < NUM_BOMBS; i++) begin
                    if (active[i]) begin
                        by[i]     <= step_y[i][9:0];
                        active[i] <= !(take_hit && hit[i]) && !floor_hit[i];
                    end else if (do_fire && free_sel[i]) begin
                        active[i] <= 1'b1;
                        bx[i]     <= sp_x;
                        by[i]     <= sp_y;
                    end
                end
            end else begin
                hit <= hit | hit_set;
            end
        end
    end
endmodule
